// File: rtl/maze_pkg.sv
// Shared definitions for the maze cell arbiter: cell codes, arbiter states and
// the row-major cell addressing helper.
package maze_pkg;

    localparam logic [1:0] CELL_OUT      = 2'b00;
    localparam logic [1:0] CELL_WALL     = 2'b01;
    localparam logic [1:0] CELL_FRONTIER = 2'b10;
    localparam logic [1:0] CELL_PATH     = 2'b11;

    localparam int MAZE_W_DEF = 64;
    localparam int MAZE_H_DEF = 64;

    typedef enum logic {
        ST_ARB,
        ST_CLEAR
    } arb_state_t;

    function automatic int xy_to_addr(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/maze_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the other requester after every grant.
module maze_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic ptr;

    assign gnt0 = en & req0 & (~ptr | ~req1);
    assign gnt1 = en & req1 & (ptr | ~req0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (gnt0) begin
            ptr <= 1'b1;
        end else if (gnt1) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/maze_cell_arbiter.sv
// Shares the single-port maze cell RAM between display, carver and player clients.
// Define MAZE_ARB_CLEAR_EN to build the grid-clear engine.
module maze_cell_arbiter
    import maze_pkg::*;
#(
    parameter int MAZE_W = MAZE_W_DEF,
    parameter int MAZE_H = MAZE_H_DEF,
    parameter int X_W    = 6,
    parameter int Y_W    = 6,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [X_W-1:0]    disp_x,
    input  logic [Y_W-1:0]    disp_y,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    input  logic              carv_req,
    input  logic              carv_we,
    input  logic [X_W-1:0]    carv_x,
    input  logic [Y_W-1:0]    carv_y,
    input  logic [1:0]        carv_wdata,
    output logic              carv_gnt,
    output logic              carv_rvalid,
    input  logic              plyr_req,
    input  logic              plyr_we,
    input  logic [X_W-1:0]    plyr_x,
    input  logic [Y_W-1:0]    plyr_y,
    input  logic [1:0]        plyr_wdata,
    output logic              plyr_gnt,
    output logic              plyr_rvalid,
    output logic [1:0]        rdata,
    output logic              oob_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done
);

    logic              clr_busy_r;
    logic              clr_done_r;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_wr;
    logic              rr_en;

    logic              sel_gnt;
    logic              sel_we;
    logic              sel_oob;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic [1:0]        sel_wdata;

    logic              disp_rvld_p1;
    logic              carv_rvld_p1;
    logic              plyr_rvld_p1;
    logic              wall_p1;
    logic              oob_p1;

    // Grants are gated by rst_n so nothing leaks out while reset is held.
    assign disp_gnt = rst_n & disp_req;
    assign rr_en    = rst_n & ~disp_req & ~clr_busy_r;
    assign clr_wr   = rst_n & clr_busy_r & ~disp_req;

    maze_rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rr_en),
        .req0  (carv_req),
        .req1  (plyr_req),
        .gnt0  (carv_gnt),
        .gnt1  (plyr_gnt)
    );

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_we    = 1'b0;
        sel_wdata = CELL_OUT;
        if (disp_gnt) begin
            sel_x = disp_x;
            sel_y = disp_y;
        end else if (carv_gnt) begin
            sel_x     = carv_x;
            sel_y     = carv_y;
            sel_we    = carv_we;
            sel_wdata = carv_wdata;
        end else if (plyr_gnt) begin
            sel_x     = plyr_x;
            sel_y     = plyr_y;
            sel_we    = plyr_we;
            sel_wdata = plyr_wdata;
        end
    end

    assign sel_gnt = disp_gnt | carv_gnt | plyr_gnt;
    assign sel_oob = (int'(sel_x) >= MAZE_W) || (int'(sel_y) >= MAZE_H);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = CELL_OUT;
        if (clr_wr) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clr_cnt;
        end else begin
            mem_en    = sel_gnt & ~sel_oob;
            mem_we    = sel_gnt & ~sel_oob & sel_we;
            mem_addr  = ADDR_W'(xy_to_addr(int'(sel_x), int'(sel_y), MAZE_W));
            mem_wdata = sel_wdata;
        end
    end

    // Stage p1: read-return qualifiers, one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_rvld_p1 <= 1'b0;
            carv_rvld_p1 <= 1'b0;
            plyr_rvld_p1 <= 1'b0;
            wall_p1      <= 1'b0;
            oob_p1       <= 1'b0;
        end else begin
            disp_rvld_p1 <= disp_gnt;
            carv_rvld_p1 <= carv_gnt & ~carv_we;
            plyr_rvld_p1 <= plyr_gnt & ~plyr_we;
            wall_p1      <= sel_gnt & sel_oob & ~sel_we;
            oob_p1       <= sel_gnt & sel_oob;
        end
    end

    assign disp_rvalid = disp_rvld_p1;
    assign carv_rvalid = carv_rvld_p1;
    assign plyr_rvalid = plyr_rvld_p1;
    assign rdata       = wall_p1 ? CELL_WALL : mem_rdata;
    assign oob_err     = oob_p1;
    assign clear_busy  = clr_busy_r;
    assign clear_done  = clr_done_r;

`ifdef MAZE_ARB_CLEAR_EN
    arb_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            clr_cnt    <= '0;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            clr_done_r <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (clear_start) begin
                        state      <= ST_CLEAR;
                        clr_cnt    <= '0;
                        clr_busy_r <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_wr) begin
                        if (clr_cnt == ADDR_W'(MAZE_W * MAZE_H - 1)) begin
                            state      <= ST_ARB;
                            clr_cnt    <= '0;
                            clr_busy_r <= 1'b0;
                            clr_done_r <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign clr_cnt            = '0;
    assign clr_busy_r         = 1'b0;
    assign clr_done_r         = 1'b0;
`endif

endmodule

// File: tb/tb_maze_cell_arbiter.sv
// Directed bench for maze_cell_arbiter: vector table for arbitration/addressing/OOB,
// hand sequences for reset and the grid-clear engine.
module tb_maze_cell_arbiter;

    localparam int MAZE_W = 64;
    localparam int MAZE_H = 64;
    localparam int X_W    = 7;
    localparam int Y_W    = 7;
    localparam int ADDR_W = 12;
    localparam int NV     = 19;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_req;
    logic [X_W-1:0]    disp_x;
    logic [Y_W-1:0]    disp_y;
    logic              disp_gnt, disp_rvalid;
    logic              carv_req, carv_we;
    logic [X_W-1:0]    carv_x;
    logic [Y_W-1:0]    carv_y;
    logic [1:0]        carv_wdata;
    logic              carv_gnt, carv_rvalid;
    logic              plyr_req, plyr_we;
    logic [X_W-1:0]    plyr_x;
    logic [Y_W-1:0]    plyr_y;
    logic [1:0]        plyr_wdata;
    logic              plyr_gnt, plyr_rvalid;
    logic [1:0]        rdata;
    logic              oob_err;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_wdata;
    logic [1:0]        mem_rdata = 2'b00;
    logic              clear_start;
    logic              clear_busy, clear_done;

    int checks = 0;
    int errors = 0;

    maze_cell_arbiter #(
        .MAZE_W(MAZE_W), .MAZE_H(MAZE_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
        .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid),
        .carv_req(carv_req), .carv_we(carv_we), .carv_x(carv_x), .carv_y(carv_y),
        .carv_wdata(carv_wdata), .carv_gnt(carv_gnt), .carv_rvalid(carv_rvalid),
        .plyr_req(plyr_req), .plyr_we(plyr_we), .plyr_x(plyr_x), .plyr_y(plyr_y),
        .plyr_wdata(plyr_wdata), .plyr_gnt(plyr_gnt), .plyr_rvalid(plyr_rvalid),
        .rdata(rdata), .oob_err(oob_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    // Cell RAM model: unwritten cells read back as the low two address bits.
    logic [1:0] mem     [0:4095];
    bit         wr_flag [0:4095] = '{default: 1'b0};

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                wr_flag[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_flag[mem_addr] ? mem[mem_addr] : mem_addr[1:0];
            end
        end
    end

    typedef struct {
        logic       dr;
        logic [6:0] dx, dy;
        logic       cr, cw;
        logic [6:0] cx, cy;
        logic [1:0] cd;
        logic       pr, pw;
        logic [6:0] px, py;
        logic [2:0] gnt;
        logic       en, we;
        logic [11:0] addr;
        logic [2:0] rv;
        logic       oob, rc;
        logic [1:0] rd;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(input logic dr, input int dx, input int dy,
                                input logic cr, input logic cw, input int cx, input int cy,
                                input int cd, input logic pr, input logic pw,
                                input int px, input int py, input logic [2:0] g,
                                input logic en, input logic we, input int addr,
                                input logic [2:0] rv, input logic oob, input logic rc,
                                input int rd);
        vec_t v;
        v.dr = dr; v.dx = 7'(dx); v.dy = 7'(dy);
        v.cr = cr; v.cw = cw; v.cx = 7'(cx); v.cy = 7'(cy); v.cd = 2'(cd);
        v.pr = pr; v.pw = pw; v.px = 7'(px); v.py = 7'(py);
        v.gnt = g; v.en = en; v.we = we; v.addr = 12'(addr);
        v.rv = rv; v.oob = oob; v.rc = rc; v.rd = 2'(rd);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        disp_req = v.dr; disp_x = v.dx; disp_y = v.dy;
        carv_req = v.cr; carv_we = v.cw; carv_x = v.cx; carv_y = v.cy; carv_wdata = v.cd;
        plyr_req = v.pr; plyr_we = v.pw; plyr_x = v.px; plyr_y = v.py; plyr_wdata = 2'b00;
    endtask

    initial begin
        // gnt/rv order {disp, carv, plyr}
        vt[0]  = mk(0,0,0, 1,0,1,0,0, 1,0,2,0,    3'b010,1,0,1,    3'b000,0,0,0);
        vt[1]  = mk(0,0,0, 0,0,1,0,0, 1,0,2,0,    3'b001,1,0,2,    3'b010,0,1,1);
        vt[2]  = mk(1,3,0, 1,0,1,0,0, 1,0,2,0,    3'b100,1,0,3,    3'b001,0,1,2);
        vt[3]  = mk(1,4,0, 1,0,1,0,0, 1,0,2,0,    3'b100,1,0,4,    3'b100,0,1,3);
        vt[4]  = mk(1,5,0, 1,0,1,0,0, 1,0,2,0,    3'b100,1,0,5,    3'b100,0,1,0);
        vt[5]  = mk(1,6,0, 1,0,1,0,0, 1,0,2,0,    3'b100,1,0,6,    3'b100,0,1,1);
        vt[6]  = mk(0,0,0, 1,0,1,0,0, 1,0,2,0,    3'b010,1,0,1,    3'b100,0,1,2);
        vt[7]  = mk(0,0,0, 1,0,1,0,0, 1,0,2,0,    3'b001,1,0,2,    3'b010,0,1,1);
        vt[8]  = mk(0,0,0, 1,0,1,0,0, 1,0,2,0,    3'b010,1,0,1,    3'b001,0,1,2);
        vt[9]  = mk(0,0,0, 1,0,1,0,0, 1,0,2,0,    3'b001,1,0,2,    3'b010,0,1,1);
        vt[10] = mk(0,0,0, 1,1,5,3,3, 0,0,0,0,    3'b010,1,1,197,  3'b001,0,1,2);
        vt[11] = mk(0,0,0, 0,0,0,0,0, 1,0,5,3,    3'b001,1,0,197,  3'b000,0,0,0);
        vt[12] = mk(0,0,0, 0,0,0,0,0, 0,0,0,0,    3'b000,0,0,0,    3'b001,0,1,3);
        vt[13] = mk(0,0,0, 0,0,0,0,0, 1,0,64,0,   3'b001,0,0,0,    3'b000,0,0,0);
        vt[14] = mk(0,0,0, 0,0,0,0,0, 0,0,0,0,    3'b000,0,0,0,    3'b001,1,1,1);
        vt[15] = mk(0,0,0, 1,1,0,64,2, 0,0,0,0,   3'b010,0,0,0,    3'b000,0,0,0);
        vt[16] = mk(0,0,0, 0,0,0,0,0, 0,0,0,0,    3'b000,0,0,0,    3'b000,1,0,0);
        vt[17] = mk(0,0,0, 1,0,63,63,0, 0,0,0,0,  3'b010,1,0,4095, 3'b000,0,0,0);
        vt[18] = mk(0,0,0, 0,0,0,0,0, 0,0,0,0,    3'b000,0,0,0,    3'b010,0,1,3);

        // Reset held with every request asserted
        rst_n = 1'b0; clear_start = 1'b0;
        disp_req = 1'b1; disp_x = 7'd0; disp_y = 7'd0;
        carv_req = 1'b1; carv_we = 1'b0; carv_x = 7'd1; carv_y = 7'd0; carv_wdata = 2'b00;
        plyr_req = 1'b1; plyr_we = 1'b0; plyr_x = 7'd2; plyr_y = 7'd0; plyr_wdata = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'({disp_gnt, carv_gnt, plyr_gnt}), 0);
        chk("rst_mem_en", int'({mem_en, mem_we}), 0);
        chk("rst_rvalid", int'({disp_rvalid, carv_rvalid, plyr_rvalid}), 0);
        chk("rst_oob_busy_done", int'({oob_err, clear_busy, clear_done}), 0);
        disp_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), int'({disp_gnt, carv_gnt, plyr_gnt}), int'(vt[i].gnt));
            chk($sformatf("v%0d_en_we", i), int'({mem_en, mem_we}), int'({vt[i].en, vt[i].we}));
            if (vt[i].en)
                chk($sformatf("v%0d_addr", i), int'(mem_addr), int'(vt[i].addr));
            if (vt[i].we)
                chk($sformatf("v%0d_wdata", i), int'(mem_wdata), int'(vt[i].cd));
            chk($sformatf("v%0d_rvalid", i), int'({disp_rvalid, carv_rvalid, plyr_rvalid}),
                int'(vt[i].rv));
            chk($sformatf("v%0d_oob", i), int'(oob_err), int'(vt[i].oob));
            if (vt[i].rc)
                chk($sformatf("v%0d_rdata", i), int'(rdata), int'(vt[i].rd));
            @(posedge clk); #1;
        end

`ifdef MAZE_ARB_CLEAR_EN
        begin
            int  wcount, exp_a, bad_a, cg_bad, disp_hits, nz;
            bit  done_seen, injected, found;
            wcount = 0; exp_a = 0; bad_a = 0; cg_bad = 0; disp_hits = 0;
            done_seen = 1'b0; injected = 1'b0;
            apply(mk(0,0,0, 0,0,1,0,0, 0,0,0,0, 3'b000,0,0,0, 3'b000,0,0,0));
            clear_start = 1'b1;
            @(posedge clk); #1;
            clear_start = 1'b0;
            carv_req = 1'b1;
            @(negedge clk);
            chk("clr_busy_start", int'(clear_busy), 1);
            for (int c = 0; c < 5000 && !done_seen; c++) begin
                if (c > 0) @(negedge clk);
                if (clear_busy && carv_gnt) cg_bad++;
                if (mem_en && mem_we) begin
                    if (mem_addr != exp_a[11:0] || mem_wdata != 2'b00) bad_a++;
                    exp_a++;
                    wcount++;
                end
                if (disp_gnt) begin
                    disp_hits++;
                    if (mem_we) bad_a++;
                end
                if (clear_done) begin
                    done_seen = 1'b1;
                    chk("clr_done_busy", int'(clear_busy), 0);
                    chk("clr_done_carv_gnt", int'(carv_gnt), 1);
                end
                @(posedge clk); #1;
                disp_req = (wcount == 2000) && !injected;
                if (disp_req) injected = 1'b1;
            end
            disp_req = 1'b0;
            chk("clr_done_seen", int'(done_seen), 1);
            chk("clr_writes", wcount, 4096);
            chk("clr_addr_seq", bad_a, 0);
            chk("clr_carv_blocked", cg_bad, 0);
            chk("clr_disp_preempt", disp_hits, 1);
            nz = 0;
            for (int a = 0; a < 4096; a++)
                if (!wr_flag[a] || mem[a] != 2'b00) nz++;
            chk("clr_grid_zero", nz, 0);

            // Reset in the middle of a clear
            found = 1'b0;
            clear_start = 1'b1;
            @(posedge clk); #1;
            clear_start = 1'b0;
            for (int c = 0; c < 2000 && !found; c++) begin
                @(negedge clk);
                if (mem_en && mem_we && mem_addr == 12'd1000) found = 1'b1;
            end
            chk("rst_mid_found", int'(found), 1);
            rst_n = 1'b0;
            #1;
            chk("rst_mid_busy", int'(clear_busy), 0);
            chk("rst_mid_mem_en", int'(mem_en), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk($sformatf("rst_mid_c%0d_done_busy", c), int'({clear_done, clear_busy}), 0);
                chk($sformatf("rst_mid_c%0d_carv_gnt", c), int'(carv_gnt), 1);
                @(posedge clk); #1;
            end
        end
`else
        apply(mk(0,0,0, 1,0,1,0,0, 0,0,0,0, 3'b000,0,0,0, 3'b000,0,0,0));
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("noclr_c%0d_done_busy", c), int'({clear_done, clear_busy}), 0);
            chk($sformatf("noclr_c%0d_carv_gnt", c), int'(carv_gnt), 1);
            @(posedge clk); #1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
